uart_frame_rx: RTL
==================

Name: uart_frame_rx

Overview:
- UART receiver: the receive-side counterpart of the team's UART frame transmitter; same parameter set and frame format (1 start bit, FRAME_WD data bits LSB first, optional parity, 1 stop bit).
- Synchronises the asynchronous serial line, finds the start bit, samples each bit at mid-bit and checks parity and stop bit.
- Presents each received frame to the core with a one-cycle done pulse and error flags.

Parameters:
- CLK_FREQUENCE, 50_000_000, system clock in Hz.
- BAUD_RATE, 9600, line rate in bit/s (9600 up to 921600).
- PARITY, "NONE", one of "NONE", "EVEN", "ODD"; any other string is treated as "NONE".
- FRAME_WD, 8, data bits per frame; 5..9 when PARITY="NONE", otherwise 5..8.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- uart_rx  in  1  serial line input; asynchronous; idles high.
- data_frame  out  FRAME_WD  last received data word; bit 0 is the first bit received.
- rx_done  out  1  one-cycle pulse: frame complete and outputs updated.
- parity_err  out  1  parity mismatch on the last frame; always 0 when PARITY="NONE".
- frame_err  out  1  stop bit sampled low on the last frame.
- rx_busy  out  1  high from start-bit detection until rx_done.

Behaviour:
Constants:
- BIT_CYC = CLK_FREQUENCE/BAUD_RATE (integer division). HALF_CYC = BIT_CYC/2.
- Baud counter width is $clog2(BIT_CYC).

Input synchronisation and edge detection:
- uart_rx passes through a 2-flop synchroniser, both flops reset to 1.
- A third flop holds the previous synchronised value.
- A falling edge is previous = 1 and current = 0.

Reset values:
- data_frame = 0; rx_done, parity_err, frame_err and rx_busy = 0.
- State = IDLE; all counters = 0.

State machine (one-hot):
- IDLE: wait for a falling edge, then go to START with the baud counter cleared.
- START: count up to HALF_CYC-1, then sample the line.
  - Line low: go to DATA with the baud counter and bit counter cleared.
  - Line high: treat as a glitch and return to IDLE; no flags, no rx_done.
- DATA: sample when the baud counter reaches BIT_CYC-1, then restart the counter.
  - Each sample shifts in MSB-first into the shift register (shift right), so after FRAME_WD samples bit 0 holds the first bit received.
  - After FRAME_WD samples, go to PARITY if PARITY≠"NONE", otherwise to STOP.
- PARITY: sample after BIT_CYC cycles.
  - EVEN: error if XOR of the data bits ≠ parity bit.
  - ODD: error if XOR of the data bits = parity bit.
- STOP: sample after BIT_CYC cycles, then go to DONE.
  - Sample low: set the internal frame error.
  - No wait for the line to go high; a break condition reports frame_err and is then re-detected only after a subsequent rising edge and falling edge.
- DONE: one cycle, then back to IDLE.
  - On this cycle: load data_frame from the shift register; load parity_err and frame_err; pulse rx_done for exactly this cycle; rx_busy drops.

Output and timing rules:
- data_frame, parity_err and frame_err change only in DONE and hold until the next DONE.
- rx_busy is high in START, DATA, PARITY and STOP.
- Latency: rx_done rises 3 to 4 clk after the stop-bit mid-point sample (2 synchroniser flops + DONE register).
- A falling edge seen during the DONE cycle is ignored; the minimum inter-frame gap is the stop bit itself.
- uart_rx activity in non-IDLE states does not restart the frame.

Reset mid-frame:
- Asynchronous return to IDLE with all outputs at their reset values.
- A frame in progress is discarded; no rx_done.

Decomposition:
- Shared package uart_pkg:
  - state one-hot localparams (IDLE, START, DATA, PARITY, STOP, DONE);
  - parity-mode encoding (NONE=2'b00, ODD=2'b01, EVEN=2'b10), shared with the transmitter;
  - function computing BIT_CYC from frequency and baud rate.
- One natural sub-module, rx_clk_gen: the baud counter, with a clear input and a mid_tick / bit_tick output. It mirrors the transmitter's clock generator.
- FSM, shift register and flags stay in the top level.

Test Plan:
All scenarios use CLK_FREQUENCE=160, BAUD_RATE=10, giving BIT_CYC=16.
- PARITY="NONE", FRAME_WD=8, send 0xA5 with stop bit high -> one rx_done pulse, data_frame=0xA5, parity_err=0, frame_err=0, rx_busy high for ~9.5 bit times.
- PARITY="EVEN", send 0x07 with parity bit 1 -> parity_err=0; resend 0x07 with parity bit 0 -> parity_err=1, data_frame=0x07.
- PARITY="ODD", FRAME_WD=5, send 0x1F with parity bit 0 -> parity_err=0, data_frame=0x1F.
- Send 0x3C with stop bit forced low -> rx_done pulses, frame_err=1; next valid frame 0x55 -> frame_err=0, data_frame=0x55.
- Low glitch on uart_rx of 5 cycles (< HALF_CYC) -> returns to IDLE; no rx_done; data_frame unchanged.
- Assert rst_n low during DATA bit 4 -> all outputs 0 immediately; after release, frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the frame receiver (and its transmitter
// counterpart): one-hot FSM state encoding, parity-mode encoding and the
// bit-period helper used by both clock generators.
package uart_pkg;

    // One-hot receiver states.
    typedef enum logic [5:0] {
        ST_IDLE   = 6'b000001,
        ST_START  = 6'b000010,
        ST_DATA   = 6'b000100,
        ST_PARITY = 6'b001000,
        ST_STOP   = 6'b010000,
        ST_DONE   = 6'b100000
    } state_t;

    // Parity-mode encoding, identical on the transmit side.
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    // Clock cycles per serial bit (integer division, truncating).
    function automatic int calc_bit_cyc(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/rx_clk_gen.sv
// Baud counter for the UART receiver.
// Ports:
//   clk      - system clock
//   rst_n    - asynchronous active-low reset
//   clr      - synchronous clear of the counter (held while idle)
//   mid_tick - counter at HALF_CYC-1 (middle of the start bit)
//   bit_tick - counter at BIT_CYC-1 (one full bit period elapsed)
// The counter wraps to zero after BIT_CYC-1 so consecutive bit_ticks are
// exactly one bit period apart without any help from the FSM.
module rx_clk_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQUENCE = 50_000_000,
    parameter int BAUD_RATE     = 9600
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic mid_tick,
    output logic bit_tick
);

    localparam int BIT_CYC  = calc_bit_cyc(CLK_FREQUENCE, BAUD_RATE);
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int CNT_W    = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg + 1'b1;
        if (clr || (cnt_reg == BIT_LAST)) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign mid_tick = (cnt_reg == HALF_LAST);
    assign bit_tick = (cnt_reg == BIT_LAST);

endmodule

// File: rtl/uart_frame_rx.sv
// UART frame receiver: 1 start bit, FRAME_WD data bits LSB first, optional
// parity bit, 1 stop bit. Synchronises the serial line, detects the start
// edge, samples every bit at mid-bit and reports each frame with a
// one-cycle rx_done pulse plus parity / framing error flags.
// Ports:
//   clk        - system clock
//   rst_n      - asynchronous active-low reset
//   uart_rx    - asynchronous serial input, idles high
//   data_frame - last received word, bit 0 = first bit on the line
//   rx_done    - one-cycle pulse, outputs valid and updated
//   parity_err - parity mismatch on last frame (0 without parity)
//   frame_err  - stop bit sampled low on last frame
//   rx_busy    - high from start-bit detection until rx_done
module uart_frame_rx
    import uart_pkg::*;
#(
    parameter int    CLK_FREQUENCE = 50_000_000,
    parameter int    BAUD_RATE     = 9600,
    parameter string PARITY        = "NONE",
    parameter int    FRAME_WD      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                uart_rx,
    output logic [FRAME_WD-1:0] data_frame,
    output logic                rx_done,
    output logic                parity_err,
    output logic                frame_err,
    output logic                rx_busy
);

    // Unknown parity strings fall back to no parity.
    localparam logic [1:0] PAR_MODE = (PARITY == "EVEN") ? PAR_EVEN :
                                      (PARITY == "ODD")  ? PAR_ODD  : PAR_NONE;

    localparam int BCNT_W = $clog2(FRAME_WD + 1);
    localparam logic [BCNT_W-1:0] BIT_LAST = BCNT_W'(FRAME_WD - 1);

    // Line synchroniser plus one history flop for edge detection.
    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;
    logic rx_bit;
    logic fall_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            prev_reg  <= 1'b1;
        end else begin
            sync1_reg <= uart_rx;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign rx_bit    = sync2_reg;
    assign fall_edge = prev_reg & ~sync2_reg;

    // Baud timing.
    logic clr;
    logic mid_tick;
    logic bit_tick;

    rx_clk_gen #(
        .CLK_FREQUENCE (CLK_FREQUENCE),
        .BAUD_RATE     (BAUD_RATE)
    ) u_clk_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .mid_tick (mid_tick),
        .bit_tick (bit_tick)
    );

    // FSM and datapath state.
    state_t              state_reg,      state_next;
    logic [FRAME_WD-1:0] shift_reg,      shift_next;
    logic [BCNT_W-1:0]   bit_cnt_reg,    bit_cnt_next;
    logic                par_int_reg,    par_int_next;
    logic [FRAME_WD-1:0] data_frame_reg, data_frame_next;
    logic                parity_err_reg, parity_err_next;
    logic                frame_err_reg,  frame_err_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        clr             = 1'b0;
        shift_next      = shift_reg;
        bit_cnt_next    = bit_cnt_reg;
        par_int_next    = par_int_reg;
        data_frame_next = data_frame_reg;
        parity_err_next = parity_err_reg;
        frame_err_next  = frame_err_reg;

        case (state_reg)
            ST_IDLE: begin
                // Counter held at zero so START times the half bit from the edge.
                clr          = 1'b1;
                bit_cnt_next = '0;
                if (fall_edge) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (mid_tick) begin
                    if (!rx_bit) begin
                        state_next   = ST_DATA;
                        clr          = 1'b1;
                        bit_cnt_next = '0;
                    end else begin
                        // Line back high at mid start bit: a glitch, not a frame.
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    // Shift right so the first bit ends up in bit 0.
                    shift_next   = {rx_bit, shift_reg[FRAME_WD-1:1]};
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    if (bit_cnt_reg == BIT_LAST) begin
                        state_next = (PAR_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    if (PAR_MODE == PAR_ODD) begin
                        par_int_next = ((^shift_reg) == rx_bit);
                    end else begin
                        par_int_next = ((^shift_reg) != rx_bit);
                    end
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    // Results are registered on entry to DONE so they are
                    // already visible during the rx_done cycle.
                    data_frame_next = shift_reg;
                    parity_err_next = (PAR_MODE != PAR_NONE) && par_int_reg;
                    frame_err_next  = ~rx_bit;
                    state_next      = ST_DONE;
                end
            end
            ST_DONE: begin
                // Unconditional: an edge during this cycle is ignored.
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg      <= '0;
            bit_cnt_reg    <= '0;
            par_int_reg    <= 1'b0;
            data_frame_reg <= '0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            shift_reg      <= shift_next;
            bit_cnt_reg    <= bit_cnt_next;
            par_int_reg    <= par_int_next;
            data_frame_reg <= data_frame_next;
            parity_err_reg <= parity_err_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    assign data_frame = data_frame_reg;
    assign parity_err = parity_err_reg;
    assign frame_err  = frame_err_reg;
    assign rx_done    = (state_reg == ST_DONE);
    assign rx_busy    = (state_reg == ST_START) || (state_reg == ST_DATA) ||
                        (state_reg == ST_PARITY) || (state_reg == ST_STOP);

endmodule
